// File: rtl/reg_status_file_pkg.sv
// Shared constants for the architectural register file with rename status:
// default geometry, ready/busy encodings and the hardwired zero register.
package reg_status_file_pkg;

    localparam int REG_NUM_DEF = 32;
    localparam int REG_W_DEF   = 5;
    localparam int TAG_W_DEF   = 4;
    localparam int DATA_W_DEF  = 32;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;
    localparam logic BUSY    = 1'b1;
    localparam logic IDLE    = 1'b0;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_status_read_port.sv
// Combinational read port: priority mux between x0, the stored value and a
// same-cycle commit bypass; otherwise reports the ROB tag to wait on.
module reg_status_read_port
    import reg_status_file_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [REG_W-1:0]  rd_reg,
    input  logic [DATA_W-1:0] st_data,
    input  logic              st_busy,
    input  logic [TAG_W-1:0]  st_tag,
    input  logic              commit_valid,
    input  logic [REG_W-1:0]  commit_reg,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [DATA_W-1:0] commit_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag
);

    // Select the read result; earlier branches take priority.
    always_comb begin
        rd_valid = VALID;
        rd_data  = '0;
        rd_tag   = '0;
        if (rd_reg == REG_W'(ZERO_REG)) begin
            rd_valid = VALID;
        end else if (st_busy == IDLE) begin
            rd_data = st_data;
        end else if (commit_valid && (commit_reg == rd_reg) && (commit_tag == st_tag)) begin
            rd_data = commit_data;
        end else begin
            rd_valid = INVALID;
            rd_tag   = st_tag;
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB
// tag), fed by the ROB commit bus and read by dispatch through two ports.
// Optional build macro REGFILE_COMMIT_TRACE_EN adds dbg_commit_cnt and dbg_a0.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              ID_valid,
    input  logic              ID_rename_en,
    input  logic [REG_W-1:0]  ID_dest_reg,
    input  logic [TAG_W-1:0]  ID_tag,
    input  logic              ROB_commit_valid,
    input  logic [REG_W-1:0]  ROB_commit_reg,
    input  logic [TAG_W-1:0]  ROB_commit_tag,
    input  logic [DATA_W-1:0] ROB_commit_data,
    input  logic [REG_W-1:0]  rd1_reg,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    output logic [TAG_W-1:0]  rd1_tag,
    input  logic [REG_W-1:0]  rd2_reg,
    output logic              rd2_valid,
    output logic [DATA_W-1:0] rd2_data,
    output logic [TAG_W-1:0]  rd2_tag
`ifdef REGFILE_COMMIT_TRACE_EN
    ,
    output logic [31:0]       dbg_commit_cnt,
    output logic [DATA_W-1:0] dbg_a0
`endif
);

    logic [DATA_W-1:0]  data_q [REG_NUM];
    logic [DATA_W-1:0]  data_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [TAG_W-1:0]   tag_q  [REG_NUM];
    logic [TAG_W-1:0]   tag_d  [REG_NUM];

    logic commit_hit;
    logic rename_hit;

    assign commit_hit = ROB_commit_valid && (ROB_commit_reg != REG_W'(ZERO_REG));
    assign rename_hit = ID_valid && ID_rename_en && (ID_dest_reg != REG_W'(ZERO_REG));

    // Next state: commit writes data and releases a matching rename, then the
    // rename (or a flush) is layered on top so it wins over the release.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (commit_hit) begin
                data_d[ROB_commit_reg] = ROB_commit_data;
                if ((busy_q[ROB_commit_reg] == BUSY) && (tag_q[ROB_commit_reg] == ROB_commit_tag)) begin
                    busy_d[ROB_commit_reg] = IDLE;
                end
            end
            if (clear) begin
                busy_d = '0;
            end else if (rename_hit) begin
                busy_d[ID_dest_reg] = BUSY;
                tag_d[ID_dest_reg]  = ID_tag;
            end
        end
    end

    // Register file and rename status state.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '{default: '0};
            busy_q <= '0;
            tag_q  <= '{default: '0};
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    reg_status_read_port #(
        .REG_W  (REG_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_rd1 (
        .rd_reg       (rd1_reg),
        .st_data      (data_q[rd1_reg]),
        .st_busy      (busy_q[rd1_reg]),
        .st_tag       (tag_q[rd1_reg]),
        .commit_valid (ROB_commit_valid),
        .commit_reg   (ROB_commit_reg),
        .commit_tag   (ROB_commit_tag),
        .commit_data  (ROB_commit_data),
        .rd_valid     (rd1_valid),
        .rd_data      (rd1_data),
        .rd_tag       (rd1_tag)
    );

    reg_status_read_port #(
        .REG_W  (REG_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_rd2 (
        .rd_reg       (rd2_reg),
        .st_data      (data_q[rd2_reg]),
        .st_busy      (busy_q[rd2_reg]),
        .st_tag       (tag_q[rd2_reg]),
        .commit_valid (ROB_commit_valid),
        .commit_reg   (ROB_commit_reg),
        .commit_tag   (ROB_commit_tag),
        .commit_data  (ROB_commit_data),
        .rd_valid     (rd2_valid),
        .rd_data      (rd2_data),
        .rd_tag       (rd2_tag)
    );

`ifdef REGFILE_COMMIT_TRACE_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Count accepted non-x0 commits; wraps naturally at 2^32.
    always_comb begin
        cnt_d = cnt_q;
        if (rdy && commit_hit) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Commit trace counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dbg_commit_cnt = cnt_q;
    assign dbg_a0         = data_q[10];
`endif

endmodule

// File: tb/tb_reg_status_file.sv
// Directed self-checking bench for reg_status_file.
module tb_reg_status_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        ID_valid;
    logic        ID_rename_en;
    logic [4:0]  ID_dest_reg;
    logic [3:0]  ID_tag;
    logic        ROB_commit_valid;
    logic [4:0]  ROB_commit_reg;
    logic [3:0]  ROB_commit_tag;
    logic [31:0] ROB_commit_data;
    logic [4:0]  rd1_reg;
    logic        rd1_valid;
    logic [31:0] rd1_data;
    logic [3:0]  rd1_tag;
    logic [4:0]  rd2_reg;
    logic        rd2_valid;
    logic [31:0] rd2_data;
    logic [3:0]  rd2_tag;
`ifdef REGFILE_COMMIT_TRACE_EN
    logic [31:0] dbg_commit_cnt;
    logic [31:0] dbg_a0;
    logic [31:0] exp_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_status_file dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .clear            (clear),
        .ID_valid         (ID_valid),
        .ID_rename_en     (ID_rename_en),
        .ID_dest_reg      (ID_dest_reg),
        .ID_tag           (ID_tag),
        .ROB_commit_valid (ROB_commit_valid),
        .ROB_commit_reg   (ROB_commit_reg),
        .ROB_commit_tag   (ROB_commit_tag),
        .ROB_commit_data  (ROB_commit_data),
        .rd1_reg          (rd1_reg),
        .rd1_valid        (rd1_valid),
        .rd1_data         (rd1_data),
        .rd1_tag          (rd1_tag),
        .rd2_reg          (rd2_reg),
        .rd2_valid        (rd2_valid),
        .rd2_data         (rd2_data),
        .rd2_tag          (rd2_tag)
`ifdef REGFILE_COMMIT_TRACE_EN
        ,
        .dbg_commit_cnt   (dbg_commit_cnt),
        .dbg_a0           (dbg_a0)
`endif
    );

    task automatic idle();
        clear            = 1'b0;
        ID_valid         = 1'b0;
        ID_rename_en     = 1'b0;
        ID_dest_reg      = '0;
        ID_tag           = '0;
        ROB_commit_valid = 1'b0;
        ROB_commit_reg   = '0;
        ROB_commit_tag   = '0;
        ROB_commit_data  = '0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
`ifdef REGFILE_COMMIT_TRACE_EN
        if (!rst && rdy && ROB_commit_valid && ROB_commit_reg != 5'd0) exp_cnt = exp_cnt + 32'd1;
`endif
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] r, input logic [3:0] t);
        ID_valid = 1'b1; ID_rename_en = 1'b1; ID_dest_reg = r; ID_tag = t;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
        ROB_commit_valid = 1'b1; ROB_commit_reg = r; ROB_commit_tag = t; ROB_commit_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; idle(); rd1_reg = 5'd5; rd2_reg = 5'd0;
`ifdef REGFILE_COMMIT_TRACE_EN
        exp_cnt = 32'd0;
`endif
        tick(); tick();
        rst = 1'b0;
        rd1_reg = 5'd5; rd2_reg = 5'd0; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h0 || rd1_tag !== 4'h0) begin
            errors++; $display("FAIL reset_x5 got v=%0b d=%h t=%h want 1/00000000/0", rd1_valid, rd1_data, rd1_tag);
        end
        checks++;
        if (rd2_valid !== 1'b1 || rd2_data !== 32'h0 || rd2_tag !== 4'h0) begin
            errors++; $display("FAIL reset_x0 got v=%0b d=%h t=%h want 1/00000000/0", rd2_valid, rd2_data, rd2_tag);
        end
    endtask

    task automatic test_rename_commit();
        rename(5'd3, 4'd7); rd1_reg = 5'd3; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h0) begin
            errors++; $display("FAIL rename_not_visible got v=%0b d=%h want 1/00000000", rd1_valid, rd1_data);
        end
        tick();
        rd1_reg = 5'd3; #1;
        checks++;
        if (rd1_valid !== 1'b0 || rd1_data !== 32'h0 || rd1_tag !== 4'd7) begin
            errors++; $display("FAIL rename_x3 got v=%0b d=%h t=%h want 0/00000000/7", rd1_valid, rd1_data, rd1_tag);
        end
        commit(5'd3, 4'd7, 32'hDEADBEEF); #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'hDEADBEEF || rd1_tag !== 4'h0) begin
            errors++; $display("FAIL bypass_x3 got v=%0b d=%h t=%h want 1/deadbeef/0", rd1_valid, rd1_data, rd1_tag);
        end
        tick();
        rd1_reg = 5'd3; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL commit_x3 got v=%0b d=%h want 1/deadbeef", rd1_valid, rd1_data);
        end
    endtask

    task automatic test_stale_commit();
        rename(5'd4, 4'd2); tick();
        rename(5'd4, 4'd9); tick();
        commit(5'd4, 4'd2, 32'h11); tick();
        rd1_reg = 5'd4; #1;
        checks++;
        if (rd1_valid !== 1'b0 || rd1_tag !== 4'd9) begin
            errors++; $display("FAIL stale_x4 got v=%0b t=%h want 0/9", rd1_valid, rd1_tag);
        end
        commit(5'd4, 4'd9, 32'h22); #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h22) begin
            errors++; $display("FAIL bypass_x4 got v=%0b d=%h want 1/00000022", rd1_valid, rd1_data);
        end
        tick();
        rd1_reg = 5'd4; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h22) begin
            errors++; $display("FAIL commit_x4 got v=%0b d=%h want 1/00000022", rd1_valid, rd1_data);
        end
        // A stale commit still writes data; a flush exposes it.
        rename(5'd9, 4'd3); tick();
        commit(5'd9, 4'd4, 32'h55); tick();
        rd1_reg = 5'd9; #1;
        checks++;
        if (rd1_valid !== 1'b0 || rd1_tag !== 4'd3) begin
            errors++; $display("FAIL stale_x9_busy got v=%0b t=%h want 0/3", rd1_valid, rd1_tag);
        end
        clear = 1'b1; tick();
        rd1_reg = 5'd9; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h55) begin
            errors++; $display("FAIL stale_x9_data got v=%0b d=%h want 1/00000055", rd1_valid, rd1_data);
        end
    endtask

    task automatic test_same_cycle();
        rename(5'd6, 4'd1); tick();
        rename(5'd6, 4'd5); commit(5'd6, 4'd1, 32'h33); tick();
        rd1_reg = 5'd6; #1;
        checks++;
        if (rd1_valid !== 1'b0 || rd1_tag !== 4'd5) begin
            errors++; $display("FAIL same_cycle_x6 got v=%0b t=%h want 0/5", rd1_valid, rd1_tag);
        end
        clear = 1'b1; tick();
        rd1_reg = 5'd6; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h33) begin
            errors++; $display("FAIL same_cycle_x6_data got v=%0b d=%h want 1/00000033", rd1_valid, rd1_data);
        end
    endtask

    task automatic test_clear();
        commit(5'd1, 4'd0, 32'h100); tick();
        commit(5'd7, 4'd0, 32'h700); tick();
        rename(5'd1, 4'd1); tick();
        rename(5'd2, 4'd2); tick();
        rename(5'd7, 4'd3); tick();
        rd1_reg = 5'd2; rd2_reg = 5'd7; #1;
        checks++;
        if (rd1_valid !== 1'b0 || rd2_valid !== 1'b0 || rd2_tag !== 4'd3) begin
            errors++; $display("FAIL pre_clear got v1=%0b v2=%0b t2=%h want 0/0/3", rd1_valid, rd2_valid, rd2_tag);
        end
        clear = 1'b1; rename(5'd8, 4'd4); commit(5'd2, 4'd2, 32'h44); tick();
        rd1_reg = 5'd1; rd2_reg = 5'd2; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h100) begin
            errors++; $display("FAIL clear_x1 got v=%0b d=%h want 1/00000100", rd1_valid, rd1_data);
        end
        checks++;
        if (rd2_valid !== 1'b1 || rd2_data !== 32'h44) begin
            errors++; $display("FAIL clear_x2 got v=%0b d=%h want 1/00000044", rd2_valid, rd2_data);
        end
        rd1_reg = 5'd7; rd2_reg = 5'd8; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h700) begin
            errors++; $display("FAIL clear_x7 got v=%0b d=%h want 1/00000700", rd1_valid, rd1_data);
        end
        checks++;
        if (rd2_valid !== 1'b1 || rd2_data !== 32'h0 || rd2_tag !== 4'h0) begin
            errors++; $display("FAIL clear_x8 got v=%0b d=%h t=%h want 1/00000000/0", rd2_valid, rd2_data, rd2_tag);
        end
    endtask

    task automatic test_x0();
        commit(5'd0, 4'd6, 32'h99); rename(5'd0, 4'd6); rd1_reg = 5'd0; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h0) begin
            errors++; $display("FAIL x0_bypass got v=%0b d=%h want 1/00000000", rd1_valid, rd1_data);
        end
        tick();
        rd1_reg = 5'd0; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h0 || rd1_tag !== 4'h0) begin
            errors++; $display("FAIL x0_after got v=%0b d=%h t=%h want 1/00000000/0", rd1_valid, rd1_data, rd1_tag);
        end
    endtask

    task automatic test_rdy();
        rdy = 1'b0; commit(5'd5, 4'd0, 32'hAA); rename(5'd5, 4'd3); rd1_reg = 5'd3; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rdy_low_read got v=%0b d=%h want 1/deadbeef", rd1_valid, rd1_data);
        end
        tick();
        rdy = 1'b1; rd1_reg = 5'd5; #1;
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'h0 || rd1_tag !== 4'h0) begin
            errors++; $display("FAIL rdy_low_hold got v=%0b d=%h t=%h want 1/00000000/0", rd1_valid, rd1_data, rd1_tag);
        end
    endtask

`ifdef REGFILE_COMMIT_TRACE_EN
    task automatic test_trace();
        commit(5'd10, 4'd0, 32'hA0A0); tick();
        checks++;
        if (dbg_a0 !== 32'hA0A0) begin
            errors++; $display("FAIL dbg_a0 got %h want 0000a0a0", dbg_a0);
        end
        checks++;
        if (dbg_commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL dbg_commit_cnt got %0d want %0d", dbg_commit_cnt, exp_cnt);
        end
    endtask
`endif

    initial begin
        rd1_reg = '0; rd2_reg = '0;
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_clear();
        test_x0();
        test_rdy();
`ifdef REGFILE_COMMIT_TRACE_EN
        test_trace();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
